// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// start is sampled only while busy=0; done pulses one cycle with D/Bout/V valid,
// and D/Bout/V then hold until the next done.
interface serial_sub_if #(parameter int WIDTH = 4);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Bin,
    input  D, Bout, V, busy, done
  );

  modport slave (
    input  start, A, B, Bin,
    output D, Bout, V, busy, done
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock LSB first,
// single full-subtractor cell with a registered borrow.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus,
  output logic [1:0]  state_dbg
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] d_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, v_q;

  logic             a_k, b_k, d_k, br_next, last_bit;
  logic [WIDTH-1:0] d_full;

  // Full-subtractor cell on the current LSBs of the operand shifters.
  always_comb begin
    a_k      = a_sh[0];
    b_k      = b_sh[0];
    d_k      = a_k ^ b_k ^ br;
    br_next  = (~a_k & b_k) | (~(a_k ^ b_k) & br);
    last_bit = (cnt == LAST);
    d_full   = {d_k, d_sh};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      d_sh   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh <= bus.A;
            b_sh <= bus.B;
            br   <= bus.Bin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          d_sh <= d_full[WIDTH-1:1];
          br   <= br_next;
          if (last_bit) begin
            // On the last bit a_k/b_k are the original operand MSBs.
            d_q    <= d_full;
            bout_q <= br_next;
            v_q    <= (a_k ^ b_k) & (a_k ^ d_k);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.D     = d_q;
  assign bus.Bout  = bout_q;
  assign bus.V     = v_q;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign state_dbg = state;
endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub (WIDTH=4): vectors, start sampling, reset abort, sweep.
module tb_serial_sub;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_cmp  = 0;
  int         n_fail = 0;

  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int       lat, busy_cyc, d_moves;
  logic     done_after, busy_after;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one operation from IDLE and returns once it is back in IDLE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    logic [W-1:0] d0;
    bus.A = a; bus.B = b; bus.Bin = bin; bus.start = 1'b1;
    d0 = bus.D;
    tick();
    bus.start = 1'b0;
    lat = 0; d_moves = 0;
    busy_cyc = int'(bus.busy);
    while (bus.done !== 1'b1 && lat < 20) begin
      if (bus.D !== d0) d_moves++;
      tick();
      lat++;
      busy_cyc += int'(bus.busy);
    end
    tick();
    done_after = bus.done;
    busy_after = bus.busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({bus.D, bus.Bout, bus.V, bus.busy, bus.done} !== 8'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=%b", {bus.D, bus.Bout, bus.V, bus.busy, bus.done}, 8'b0);
    end
    n_cmp++;
    if (state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_state got=%0d want=0", state_dbg);
    end
  endtask

  task automatic test_basic;
    do_op(4'b1010, 4'b0001, 1'b1);
    n_cmp++;
    if (lat !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d want=4", lat); end
    n_cmp++;
    if (busy_cyc !== 5) begin n_fail++; $display("FAIL basic_busy_cycles got=%0d want=5", busy_cyc); end
    n_cmp++;
    if (d_moves !== 0) begin n_fail++; $display("FAIL basic_d_held_in_shift got=%0d want=0", d_moves); end
    n_cmp++;
    if ({bus.D, bus.Bout, bus.V} !== 6'b1000_0_0) begin
      n_fail++; $display("FAIL basic_result got=%b want=%b", {bus.D, bus.Bout, bus.V}, 6'b1000_0_0);
    end
    n_cmp++;
    if ({done_after, busy_after} !== 2'b00) begin
      n_fail++; $display("FAIL basic_back_to_idle got=%b want=00", {done_after, busy_after});
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [5] = '{4'b0011, 4'b1000, 4'b0111, 4'b0000, 4'b1111};
    logic [W-1:0] vb [5] = '{4'b0101, 4'b0001, 4'b1111, 4'b0000, 4'b1111};
    logic         vi [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [5:0]   ve [5] = '{6'b1110_1_0, 6'b0111_0_1, 6'b1000_1_1, 6'b1111_1_0, 6'b0000_0_0};
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], vi[i]);
      n_cmp++;
      if ({bus.D, bus.Bout, bus.V} !== ve[i]) begin
        n_fail++; $display("FAIL vector%0d {D,Bout,V} got=%b want=%b", i, {bus.D, bus.Bout, bus.V}, ve[i]);
      end
    end
  endtask

  task automatic test_ignored_start;
    int dones;
    bus.A = 4'b1010; bus.B = 4'b0001; bus.Bin = 1'b1; bus.start = 1'b1;
    tick();                                          // edge 0
    bus.start = 1'b0;
    tick();                                          // edge 1
    bus.A = 4'b0000; bus.B = 4'b0001; bus.start = 1'b1;
    tick();                                          // edge 2, in SHIFT
    bus.start = 1'b0;
    tick(); tick();                                  // edges 3, 4
    n_cmp++;
    if ({bus.done, bus.D} !== 5'b1_1000) begin
      n_fail++; $display("FAIL ignore_first_result {done,D} got=%b want=11000", {bus.done, bus.D});
    end
    bus.start = 1'b1;
    tick();                                          // edge 5, in DONE
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_done_start busy got=%b want=0", bus.busy); end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      dones += int'(bus.done | bus.busy);
    end
    n_cmp++;
    if (dones !== 0) begin n_fail++; $display("FAIL ignore_no_extra_op got=%0d want=0", dones); end
    n_cmp++;
    if (bus.D !== 4'b1000) begin n_fail++; $display("FAIL ignore_d_held got=%b want=1000", bus.D); end
  endtask

  task automatic test_back_to_back;
    int t_done [$];
    bus.A = 4'b0011; bus.B = 4'b0101; bus.Bin = 1'b0; bus.start = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (bus.done === 1'b1) t_done.push_back(t);
    end
    bus.start = 1'b0;
    n_cmp++;
    if (t_done.size() !== 3) begin
      n_fail++; $display("FAIL b2b_count got=%0d want=3", t_done.size());
    end else begin
      n_cmp++;
      if (t_done[0] !== 5 || t_done[1] !== 11 || t_done[2] !== 17) begin
        n_fail++; $display("FAIL b2b_spacing got=%0d,%0d,%0d want=5,11,17", t_done[0], t_done[1], t_done[2]);
      end
    end
    n_cmp++;
    if ({bus.D, bus.Bout, bus.busy} !== 6'b1110_1_0) begin
      n_fail++; $display("FAIL b2b_result {D,Bout,busy} got=%b want=111010", {bus.D, bus.Bout, bus.busy});
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    bus.A = 4'b1010; bus.B = 4'b0001; bus.Bin = 1'b1; bus.start = 1'b1;
    tick();                                          // edge 0
    bus.start = 1'b0;
    tick();                                          // edge 1
    rst = 1'b1;
    tick();                                          // edge 2
    rst = 1'b0;
    n_cmp++;
    if ({bus.D, bus.Bout, bus.V, bus.busy, bus.done} !== 8'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs got=%b want=%b", {bus.D, bus.Bout, bus.V, bus.busy, bus.done}, 8'b0);
    end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      dones += int'(bus.done);
    end
    n_cmp++;
    if (dones !== 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d want=0", dones); end
    rst = 1'b1; bus.start = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_beats_start busy got=%b want=0", bus.busy); end
    do_op(4'b1010, 4'b0001, 1'b1);
    n_cmp++;
    if (lat !== 4 || {bus.D, bus.Bout, bus.V} !== 6'b1000_0_0) begin
      n_fail++; $display("FAIL rst_recover lat=%0d {D,Bout,V}=%b want lat=4 100000", lat, {bus.D, bus.Bout, bus.V});
    end
  endtask

  task automatic test_sweep;
    int diff, sa, sb, sd;
    logic [5:0] exp_v;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          do_op(W'(a), W'(b), bi[0]);
          diff = a - b - bi;
          sa = (a >= 8) ? a - 16 : a;
          sb = (b >= 8) ? b - 16 : b;
          sd = sa - sb - bi;
          exp_v = {diff[3:0], (diff < 0) ? 1'b1 : 1'b0, (sd < -8 || sd > 7) ? 1'b1 : 1'b0};
          n_cmp++;
          if ({bus.D, bus.Bout, bus.V} !== exp_v) begin
            n_fail++; $display("FAIL sweep a=%0d b=%0d bin=%0d got=%b want=%b", a, b, bi, {bus.D, bus.Bout, bus.V}, exp_v);
          end
          n_cmp++;
          if (lat !== 4 || done_after !== 1'b0) begin
            n_fail++; $display("FAIL sweep_done_once a=%0d b=%0d bin=%0d lat=%0d done_after=%b want 4/0", a, b, bi, lat, done_after);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
